// File: rtl/mat_mul_pkg.sv
// Shared state encoding and sizing helpers for the mat_mul stream sequencer.
package mat_mul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN
    } seq_state_t;

    // Bits needed to hold every count from 0 up to and including max_count.
    function automatic int cnt_w(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

    localparam int DEF_ROWS_A  = 3;
    localparam int DEF_COLS_A  = 4;
    localparam int DEF_COLS_B  = 1;
    localparam int DEF_TIMEOUT = 64;

    localparam int NA    = DEF_ROWS_A * DEF_COLS_A;
    localparam int NB    = DEF_COLS_A * DEF_COLS_B;
    localparam int NC    = DEF_ROWS_A * DEF_COLS_B;
    localparam int IDX_W = cnt_w(NA + NB);
    localparam int TMO_W = cnt_w(DEF_TIMEOUT);

endpackage

// File: rtl/mat_mul_seq_tmo.sv
// Clear/count watchdog for the wait-for-result phase; expired_o flags the last allowed cycle.
module mat_mul_seq_tmo #(
    parameter int LIMIT = 64,
    parameter int CNT_W = 7
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CNT_W-1:0] count_q, count_d;

    assign expired_o = (count_q == CNT_W'(LIMIT - 1));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !expired_o) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mat_mul_seq.sv
// Deserializes A/B operand words for one mat_mul operation, waits for C with a
// timeout, and streams C back out row-major.
module mat_mul_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ROWS_A     = 3,
    parameter int COLS_A     = 4,
    parameter int COLS_B     = 1,
    parameter int TIMEOUT    = 64
) (
    input  logic                                          clk,
    input  logic                                          rstn,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    input  logic [DATA_WIDTH-1:0]                         s_data,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic [DATA_WIDTH-1:0]                         m_data,
    output logic                                          m_last,
    output logic                                          mm_in_valid,
    output logic [ROWS_A-1:0][COLS_A-1:0][DATA_WIDTH-1:0] mm_a,
    output logic [COLS_A-1:0][COLS_B-1:0][DATA_WIDTH-1:0] mm_b,
    input  logic [ROWS_A-1:0][COLS_B-1:0][DATA_WIDTH-1:0] mm_c,
    input  logic                                          mm_out_valid,
    output logic                                          mm_out_ready,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          err_timeout
);

    import mat_mul_pkg::seq_state_t;
    import mat_mul_pkg::ST_IDLE;
    import mat_mul_pkg::ST_LOAD;
    import mat_mul_pkg::ST_ISSUE;
    import mat_mul_pkg::ST_WAIT;
    import mat_mul_pkg::ST_DRAIN;
    import mat_mul_pkg::cnt_w;

    localparam int NA    = ROWS_A * COLS_A;
    localparam int NB    = COLS_A * COLS_B;
    localparam int NC    = ROWS_A * COLS_B;
    localparam int NLD   = NA + NB;
    localparam int IDX_W = cnt_w(NLD);
    localparam int ODX_W = cnt_w(NC);
    localparam int TMO_W = cnt_w(TIMEOUT);

    // Flat row-major views: element k of a_q sits at the same bits as mm_a[k/COLS_A][k%COLS_A].
    seq_state_t                         state_q, state_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [ODX_W-1:0]                   odx_q, odx_d;
    logic [NA-1:0][DATA_WIDTH-1:0]      a_q, a_d;
    logic [NB-1:0][DATA_WIDTH-1:0]      b_q, b_d;
    logic [NC-1:0][DATA_WIDTH-1:0]      c_q, c_d;
    logic                               err_q, err_d;
    logic                               done_q, done_d;
    logic                               run_q;
    logic                               s_hs, m_hs, tmo_expired;

    assign s_ready      = run_q && (state_q == ST_IDLE || state_q == ST_LOAD);
    assign m_valid      = (state_q == ST_DRAIN);
    assign m_last       = m_valid && (odx_q == ODX_W'(NC - 1));
    assign mm_in_valid  = (state_q == ST_ISSUE);
    assign mm_out_ready = (state_q == ST_WAIT);
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign err_timeout  = err_q;
    assign mm_a         = a_q;
    assign mm_b         = b_q;
    assign s_hs         = s_valid && s_ready;
    assign m_hs         = m_valid && m_ready;

    mat_mul_seq_tmo #(
        .LIMIT (TIMEOUT),
        .CNT_W (TMO_W)
    ) u_tmo (
        .clk       (clk),
        .rstn      (rstn),
        .clr_i     (state_q == ST_ISSUE),
        .en_i      (state_q == ST_WAIT),
        .expired_o (tmo_expired)
    );

    // idx_q is 0 whenever the FSM sits in IDLE, so one decoder serves both loading states.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        a_d = a_q;
        b_d = b_q;
        if (s_hs) begin
            for (int k = 0; k < NA; k++) begin
                if (idx_q == IDX_W'(k)) a_d[k] = s_data;
            end
            for (int k = 0; k < NB; k++) begin
                if (idx_q == IDX_W'(NA + k)) b_d[k] = s_data;
            end
        end
    end

    always_comb begin
        m_data = '0;
        for (int k = 0; k < NC; k++) begin
            if (odx_q == ODX_W'(k)) m_data = c_q[k];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        odx_d   = odx_q;
        c_d     = c_q;
        err_d   = err_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_hs) begin
                    err_d = 1'b0;
                    if (NLD == 1) begin
                        state_d = ST_ISSUE;
                    end else begin
                        idx_d   = IDX_W'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (s_hs) begin
                    if (idx_q == IDX_W'(NLD - 1)) begin
                        idx_d   = '0;
                        state_d = ST_ISSUE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // A result arriving on the last allowed cycle still wins over the abort.
                if (mm_out_valid) begin
                    c_d     = mm_c;
                    odx_d   = '0;
                    state_d = ST_DRAIN;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (m_hs) begin
                    if (odx_q == ODX_W'(NC - 1)) begin
                        odx_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        odx_d = odx_q + ODX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            odx_q   <= '0;
            // NOTE: the operand and result arrays are reset too, because they drive outputs that must read 0 in reset.
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            idx_q   <= idx_d;
            odx_q   <= odx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            err_q   <= err_d;
            done_q  <= done_d;
            run_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mat_mul_seq.sv
// Directed bench for mat_mul_seq with a behavioural mat_mul stub and hand-computed results.
module tb_mat_mul_seq;

    localparam int DW  = 32;
    localparam int RA  = 3;
    localparam int CA  = 4;
    localparam int CB  = 1;
    localparam int TMO = 64;

    logic                        clk = 1'b0;
    logic                        rstn;
    logic                        s_valid, s_ready;
    logic [DW-1:0]               s_data;
    logic                        m_valid, m_ready, m_last;
    logic [DW-1:0]               m_data;
    logic                        mm_in_valid, mm_out_valid, mm_out_ready;
    logic [RA-1:0][CA-1:0][DW-1:0] mm_a;
    logic [CA-1:0][CB-1:0][DW-1:0] mm_b;
    logic [RA-1:0][CB-1:0][DW-1:0] mm_c;
    logic                        busy, done, err_timeout;

    int n_vec = 0;
    int n_err = 0;

    logic stub_on;
    int   stub_lat;
    int   lat_cnt;

    mat_mul_seq #(
        .DATA_WIDTH (DW), .ROWS_A (RA), .COLS_A (CA), .COLS_B (CB), .TIMEOUT (TMO)
    ) dut (
        .clk (clk), .rstn (rstn),
        .s_valid (s_valid), .s_ready (s_ready), .s_data (s_data),
        .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data), .m_last (m_last),
        .mm_in_valid (mm_in_valid), .mm_a (mm_a), .mm_b (mm_b), .mm_c (mm_c),
        .mm_out_valid (mm_out_valid), .mm_out_ready (mm_out_ready),
        .busy (busy), .done (done), .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    // Stub mat_mul: latches the product on in_valid, raises out_valid stub_lat cycles later.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mm_out_valid <= 1'b0;
            lat_cnt      <= 0;
            mm_c         <= '0;
        end else begin
            if (mm_out_valid && mm_out_ready) mm_out_valid <= 1'b0;
            if (mm_in_valid && stub_on) begin
                mm_c[0][0] <= mm_a[0][0]*mm_b[0][0] + mm_a[0][1]*mm_b[1][0] + mm_a[0][2]*mm_b[2][0] + mm_a[0][3]*mm_b[3][0];
                mm_c[1][0] <= mm_a[1][0]*mm_b[0][0] + mm_a[1][1]*mm_b[1][0] + mm_a[1][2]*mm_b[2][0] + mm_a[1][3]*mm_b[3][0];
                mm_c[2][0] <= mm_a[2][0]*mm_b[0][0] + mm_a[2][1]*mm_b[1][0] + mm_a[2][2]*mm_b[2][0] + mm_a[2][3]*mm_b[3][0];
                lat_cnt    <= stub_lat;
            end else if (lat_cnt > 0) begin
                lat_cnt <= lat_cnt - 1;
                if (lat_cnt == 1) mm_out_valid <= 1'b1;
            end
        end
    end

    // Monitor samples mid-cycle, after stimulus settles and before the next rising edge.
    int cyc = 0, acc_cnt = 0, last_acc_cyc = 0;
    int issue_cnt = 0, issue_cyc = 0, acc_at_issue = 0;
    int mv_cnt = 0, bad_cnt = 0;
    always @(negedge clk) begin
        #2;
        cyc <= cyc + 1;
        if (s_valid && s_ready) begin
            acc_cnt      <= acc_cnt + 1;
            last_acc_cyc <= cyc;
        end
        if (mm_in_valid) begin
            issue_cnt    <= issue_cnt + 1;
            issue_cyc    <= cyc;
            acc_at_issue <= acc_cnt;
        end
        if (m_valid) mv_cnt <= mv_cnt + 1;
        if (m_valid && s_ready) bad_cnt <= bad_cnt + 1;
    end

    logic [31:0] st_basic [16] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8,
                                   32'd0, 32'd1, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    logic [31:0] st_twos  [16] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2,
                                   32'd2, 32'd2, 32'd2, 32'd2, 32'd3, 32'd3, 32'd3, 32'd3};
    logic [31:0] st_ident [16] = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd0,
                                   32'd0, 32'd0, 32'd1, 32'd0, 32'd4, 32'd5, 32'd6, 32'd7};
    logic [31:0] c_basic [3] = '{32'd10, 32'd26, 32'd2};
    logic [31:0] c_24    [3] = '{32'd24, 32'd24, 32'd24};
    logic [31:0] c_ident [3] = '{32'd4, 32'd5, 32'd6};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_s_ready"},      32'(s_ready),      32'd0);
        check({tag, "_m_valid"},      32'(m_valid),      32'd0);
        check({tag, "_m_last"},       32'(m_last),       32'd0);
        check({tag, "_mm_in_valid"},  32'(mm_in_valid),  32'd0);
        check({tag, "_mm_out_ready"}, 32'(mm_out_ready), 32'd0);
        check({tag, "_busy"},         32'(busy),         32'd0);
        check({tag, "_done"},         32'(done),         32'd0);
        check({tag, "_err_timeout"},  32'(err_timeout),  32'd0);
        check({tag, "_mm_a_zero"},    32'(|mm_a),        32'd0);
        check({tag, "_mm_b_zero"},    32'(|mm_b),        32'd0);
    endtask

    // Called at a falling edge; returns at the falling edge after the last handshake.
    task automatic send_stream(input string tag, input logic [31:0] w [16], input bit gaps);
        for (int i = 0; i < 16; i++) begin
            int guard = 0;
            s_valid = 1'b1;
            s_data  = w[i];
            while (!s_ready && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            if (!s_ready) begin
                check({tag, "_s_ready_wait"}, 32'(s_ready), 32'd1);
                s_valid = 1'b0;
                return;
            end
            @(negedge clk);
            if (gaps) begin
                s_valid = 1'b0;
                s_data  = 32'hDEAD_BEEF;
                @(negedge clk);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic recv_result(input string tag, input logic [31:0] exp_w [3],
                               input int stall_at, input int stall_len);
        for (int k = 0; k < 3; k++) begin
            int guard = 0;
            while (!m_valid && guard < 500) begin
                @(negedge clk);
                guard++;
            end
            check({tag, "_m_valid"}, 32'(m_valid), 32'd1);
            if (!m_valid) return;
            if (k == stall_at) begin
                m_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    check({tag, "_bp_valid"}, 32'(m_valid), 32'd1);
                    check({tag, "_bp_data"},  m_data, exp_w[k]);
                end
                m_ready = 1'b1;
            end
            check({tag, "_word"}, m_data, exp_w[k]);
            check({tag, "_last"}, 32'(m_last), 32'(k == 2));
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int iss0, acc0, mv0, bad0, guard;
        rstn = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        stub_on = 1'b1; stub_lat = 3;
        #2;
        check_reset("rst0");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Basic operation.
        iss0 = issue_cnt;
        send_stream("t1", st_basic, 1'b0);
        recv_result("t1", c_basic, -1, 0);
        check("t1_issue_cnt", issue_cnt - iss0, 1);

        // Input gaps: one issue, exactly one cycle after the 16th accepted word.
        iss0 = issue_cnt; acc0 = acc_cnt;
        send_stream("t2", st_basic, 1'b1);
        recv_result("t2", c_basic, -1, 0);
        check("t2_issue_cnt",   issue_cnt - iss0, 1);
        check("t2_issue_words", acc_at_issue - acc0, 16);
        check("t2_issue_delay", issue_cyc - last_acc_cyc, 1);

        // Output backpressure on the second word.
        send_stream("t3", st_basic, 1'b0);
        recv_result("t3", c_basic, 1, 5);

        // Timeout: counted from the edge on which mat_mul accepts in_valid.
        stub_on = 1'b0;
        mv0 = mv_cnt;
        send_stream("t4", st_basic, 1'b0);
        check("t4_issue", 32'(mm_in_valid), 32'd1);
        for (int k = 1; k <= TMO + 1; k++) begin
            @(negedge clk);
            if (k == TMO)     check("t4_err_early", 32'(err_timeout), 32'd0);
            if (k == TMO + 1) check("t4_err_set",   32'(err_timeout), 32'd1);
        end
        check("t4_busy_idle", 32'(busy), 32'd0);
        check("t4_s_ready_idle", 32'(s_ready), 32'd1);
        @(negedge clk);
        check("t4_no_m_valid", mv_cnt - mv0, 0);
        check("t4_err_sticky", 32'(err_timeout), 32'd1);
        stub_on = 1'b1;
        send_stream("t4b", st_basic, 1'b0);
        check("t4_err_cleared", 32'(err_timeout), 32'd0);
        recv_result("t4b", c_basic, -1, 0);

        // Reset while waiting for the result.
        stub_lat = 20;
        send_stream("t5w", st_basic, 1'b0);
        repeat (3) @(negedge clk);
        check("t5w_in_wait", 32'(mm_out_ready), 32'd1);
        rstn = 1'b0;
        #1;
        check_reset("t5w");
        @(negedge clk);
        rstn = 1'b1;
        stub_lat = 3;

        // Reset while draining.
        m_ready = 1'b0;
        send_stream("t5d", st_basic, 1'b0);
        guard = 0;
        while (!m_valid && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("t5d_in_drain", 32'(m_valid), 32'd1);
        rstn = 1'b0;
        #1;
        check_reset("t5d");
        @(negedge clk);
        rstn = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        check("t5d_no_done", 32'(done), 32'd0);
        send_stream("t5", st_twos, 1'b0);
        recv_result("t5", c_24, -1, 0);

        // Back-to-back: second stream offered while the first result drains.
        bad0 = bad_cnt;
        fork
            begin
                send_stream("t6a", st_basic, 1'b0);
                recv_result("t6a", c_basic, 0, 3);
            end
            begin
                int g = 0;
                while (!m_valid && g < 500) begin
                    @(negedge clk);
                    g++;
                end
                check("t6_s_ready_drain", 32'(s_ready), 32'd0);
                send_stream("t6b", st_ident, 1'b0);
            end
        join
        recv_result("t6b", c_ident, -1, 0);
        check("t6_no_ready_in_drain", bad_cnt - bad0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
